// File: rtl/dw_sqrt.sv
// dw_sqrt: pipelined unsigned integer square root, root = floor(sqrt(a)).
// Stage 0 registers the operand. Every later register level resolves one
// root bit MSB-first using a restoring digit recurrence. The last level
// drives root/valid_out, so a result appears RW edges after its operand
// was sampled.
//
// Handshake: valid_in qualifies a on each rising edge. There is no ready,
// because the pipeline never stalls. Each accepted operand produces exactly
// one valid_out pulse RW cycles later, in issue order. Idle cycles travel
// down the pipe as bubbles.
module dw_sqrt #(
   parameter int WIDTH = 20
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [WIDTH-1:0]     a,
   input  logic                 valid_in,
   output logic [WIDTH/2-1:0]   root,
   output logic                 valid_out
);

   localparam int RW    = WIDTH / 2;
   // The remainder never exceeds 2*root, which needs RW+1 bits. Two more
   // bits are brought down before each compare, so the trial value is
   // {root, 01} and fits in RW+2 bits.
   localparam int REM_W = RW + 2;

   // Reject odd or too-small radicand widths at elaboration time.
   if ((WIDTH % 2) != 0 || WIDTH < 2) begin : g_bad_width
      $error("dw_sqrt: WIDTH must be even and at least 2");
   end

   // Per-stage state. Index s holds the operand that has resolved s root bits.
   logic [RW-1:0]             vld_q, vld_d;
   logic [RW-1:0][WIDTH-1:0]  rad_q, rad_d;   // radicand bits not yet consumed, MSB-aligned
   logic [RW-1:0][REM_W-1:0]  rem_q, rem_d;   // partial remainder
   logic [RW-1:0][RW-1:0]     rt_q,  rt_d;    // partial root

   // Result of applying one recurrence step to each stage's contents.
   logic [RW-1:0][WIDTH-1:0]  rad_nx;
   logic [RW-1:0][REM_W-1:0]  rem_nx;
   logic [RW-1:0][RW-1:0]     rt_nx;

   logic [RW-1:0]             root_q, root_d;
   logic                      valid_out_q, valid_out_d;

   // Only part of each stage's radicand and remainder feeds the next step.
   // The reduction below marks the remaining bits as intentionally unused.
   logic                      unused_bits;
   assign unused_bits = ^{rad_q, rem_q};

   // One restoring square-root step per stage: bring down two radicand bits
   // and subtract the trial value {root, 01} when it fits.
   always_comb begin : p_step
      logic [REM_W-1:0] r_try;
      logic [REM_W-1:0] trial;
      r_try  = '0;
      trial  = '0;
      rad_nx = '0;
      rem_nx = '0;
      rt_nx  = '0;
      for (int s = 0; s < RW; s++) begin
         r_try     = {rem_q[s][REM_W-3:0], rad_q[s][WIDTH-1 -: 2]};
         trial     = {rt_q[s], 2'b01};
         rad_nx[s] = rad_q[s] << 2;
         if (r_try >= trial) begin
            rem_nx[s] = r_try - trial;
            rt_nx[s]  = (rt_q[s] << 1) | RW'(1);
         end else begin
            rem_nx[s] = r_try;
            rt_nx[s]  = rt_q[s] << 1;
         end
      end
   end

   // Next-state: valid bits always advance, data loads only behind a valid
   // bit, and the output root holds its value during bubbles.
   always_comb begin
      vld_d       = '0;
      rad_d       = rad_q;
      rem_d       = rem_q;
      rt_d        = rt_q;
      root_d      = root_q;
      valid_out_d = 1'b0;

      vld_d[0] = valid_in;
      if (valid_in) begin
         rad_d[0] = a;
         rem_d[0] = '0;
         rt_d[0]  = '0;
      end

      for (int s = 1; s < RW; s++) begin
         vld_d[s] = vld_q[s-1];
         if (vld_q[s-1]) begin
            rad_d[s] = rad_nx[s-1];
            rem_d[s] = rem_nx[s-1];
            rt_d[s]  = rt_nx[s-1];
         end
      end

      valid_out_d = vld_q[RW-1];
      if (vld_q[RW-1]) begin
         root_d = rt_nx[RW-1];
      end
   end

   // Pipeline registers. Reset empties the pipe and clears the output.
   always_ff @(posedge clk) begin
      if (reset) begin
         vld_q       <= '0;
         rad_q       <= '0;
         rem_q       <= '0;
         rt_q        <= '0;
         root_q      <= '0;
         valid_out_q <= 1'b0;
      end else begin
         vld_q       <= vld_d;
         rad_q       <= rad_d;
         rem_q       <= rem_d;
         rt_q        <= rt_d;
         root_q      <= root_d;
         valid_out_q <= valid_out_d;
      end
   end

   assign root      = root_q;
   assign valid_out = valid_out_q;

endmodule

// File: tb/tb_dw_sqrt.sv
// Self-checking bench for dw_sqrt: cycle-stamped scoreboard plus directed
// boundary, bubble, reset-flush and random-density scenarios.
module tb_dw_sqrt;

   localparam int W  = 20;
   localparam int RW = W / 2;

   // ---------------- clock / reset ----------------
   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic [W-1:0]  a = '0;
   logic          valid_in = 1'b0;
   logic [RW-1:0] root;
   logic          valid_out;

   always #5 clk = ~clk;

   dw_sqrt #(.WIDTH(W)) dut (
      .clk       (clk),
      .reset     (reset),
      .a         (a),
      .valid_in  (valid_in),
      .root      (root),
      .valid_out (valid_out)
   );

   // ---------------- scoreboard state ----------------
   logic [RW-1:0] exp_q[$];      // expected roots in issue order
   int            exp_cyc_q[$];  // edge index at which each result must appear
   logic [RW-1:0] model_root = '0;
   int            cyc = 0;
   int            n_cmp = 0;
   int            n_err = 0;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s @edge %0d: got %0d expected %0d", tag, cyc, obs, exp);
      end
   endtask

   // Reference floor(sqrt(x)) by binary search over candidate roots.
   function automatic logic [RW-1:0] isqrt(input logic [W-1:0] x);
      longint lo, hi, mid;
      lo = 0;
      hi = (64'd1 << RW) - 1;
      while (lo < hi) begin
         mid = (lo + hi + 1) / 2;
         if (mid * mid <= longint'(x)) lo = mid;
         else                          hi = mid - 1;
      end
      return lo[RW-1:0];
   endfunction

   // ---------------- driver tasks ----------------
   // Drives one clock cycle of inputs. The values are sampled by the next
   // rising edge (cyc+1), and the result is due RW edges after that.
   task automatic drive(input logic v, input logic [W-1:0] av, input logic r);
      @(negedge clk);
      reset    = r;
      valid_in = v;
      a        = av;
      if (r) begin
         exp_q.delete();
         exp_cyc_q.delete();
         model_root = '0;
      end else if (v) begin
         exp_q.push_back(isqrt(av));
         exp_cyc_q.push_back(cyc + 1 + RW);
      end
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) drive(1'b0, W'($urandom), 1'b0);
   endtask

   // ---------------- monitor ----------------
   // Compares outputs 1ns after every rising edge. A result due this edge must
   // be present. Otherwise valid_out must be low and root must hold.
   always @(posedge clk) begin
      #1;
      cyc++;
      if (exp_q.size() > 0 && exp_cyc_q[0] == cyc) begin
         check_eq("valid_out_due", {31'd0, valid_out}, 32'd1);
         check_eq("root_value", {{(32-RW){1'b0}}, root}, {{(32-RW){1'b0}}, exp_q[0]});
         model_root = exp_q[0];
         void'(exp_q.pop_front());
         void'(exp_cyc_q.pop_front());
      end else begin
         check_eq("valid_out_idle", {31'd0, valid_out}, 32'd0);
         check_eq("root_hold", {{(32-RW){1'b0}}, root}, {{(32-RW){1'b0}}, model_root});
      end
   end

   // ---------------- stimulus ----------------
   logic [W-1:0] bnd [7];
   int dens;

   initial begin
      bnd[0] = 20'd0;       bnd[1] = 20'd1;       bnd[2] = 20'd3;
      bnd[3] = 20'd4;       bnd[4] = 20'd1046528; bnd[5] = 20'd1046529;
      bnd[6] = 20'd1048575;

      // The first rising edge is sampled with reset high.
      @(negedge clk);
      check_eq("reset_valid_out", {31'd0, valid_out}, 32'd0);
      check_eq("reset_root", {{(32-RW){1'b0}}, root}, 32'd0);

      // Two operands, a two-cycle gap, then a third operand.
      drive(1'b1, 20'd441, 1'b0);
      drive(1'b1, 20'd1737, 1'b0);
      drive(1'b0, W'($urandom), 1'b0);
      drive(1'b0, W'($urandom), 1'b0);
      drive(1'b1, 20'd5833, 1'b0);
      idle(RW + 2);

      // Boundary values issued back-to-back.
      for (int i = 0; i < 7; i++) drive(1'b1, bnd[i], 1'b0);
      idle(RW + 2);

      // A toggles while valid_in stays low, so no output appears.
      idle(20);

      // Reset flushes in-flight operands.
      for (int i = 0; i < 5; i++) drive(1'b1, W'($urandom), 1'b0);
      idle(2);
      drive(1'b1, W'($urandom), 1'b1);   // operand in the reset cycle is discarded
      @(negedge clk);
      check_eq("flush_valid_out", {31'd0, valid_out}, 32'd0);
      check_eq("flush_root", {{(32-RW){1'b0}}, root}, 32'd0);
      reset    = 1'b0;
      valid_in = 1'b0;
      drive(1'b1, 20'd100, 1'b0);
      idle(RW + 5);

      // Random operands at varying valid densities.
      for (int blk = 0; blk < 40; blk++) begin
         dens = $urandom_range(10, 100);
         for (int i = 0; i < 250; i++) begin
            if ($urandom_range(0, 15) == 0)
               drive($urandom_range(0, 99) < dens, bnd[$urandom_range(0, 6)], 1'b0);
            else
               drive($urandom_range(0, 99) < dens, W'($urandom), 1'b0);
         end
      end
      idle(RW + 3);

      check_eq("drain_pending", exp_q.size(), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   // Time bound so the run always ends.
   initial begin
      #2_000_000;
      n_err++;
      $display("FAIL timeout: got no completion expected completion");
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/dw_sqrt.md
DW_SQRT -- requirements
Module: dw_sqrt

Interface
REQ-001 The block SHALL have parameter WIDTH, default 20, meaning the radicand width; it SHALL be even and at least 2.
REQ-002 The block SHALL have derived constant RW = WIDTH/2, meaning the root width (10 at default).
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset sampled on the rising edge of clk.
REQ-005 The block SHALL have port a, input, WIDTH bits: unsigned radicand.
REQ-006 The block SHALL have port valid_in, input, 1 bit: a is sampled as an operand on every rising edge where valid_in=1.
REQ-007 The block SHALL have port root, output, RW bits: unsigned floor(sqrt(a)) of the operand emerging from the pipeline; registered.
REQ-008 The block SHALL have port valid_out, output, 1 bit: high for exactly one cycle per accepted operand, while root carries that operand's result; registered.

Function
REQ-009 The block SHALL compute root = floor(sqrt(a)) exactly for every a in 0..2^WIDTH-1, treating a as unsigned.
REQ-010 Construction SHALL be a pipeline of RW stages, each resolving one root bit MSB-first (restoring or non-restoring digit recurrence); no multipliers or lookup tables.
REQ-011 Each stage SHALL carry its partial root, partial remainder, remaining radicand bits and a stage-valid bit.
REQ-012 Latency SHALL be RW cycles: valid_in=1 sampled at edge N gives valid_out=1 and its root visible after edge N+RW (10 at default).
REQ-013 Throughput SHALL be one operand per cycle; back-to-back operands SHALL produce back-to-back results in issue order.
REQ-014 There SHALL be no backpressure; an operand is never dropped or stalled once accepted.
REQ-015 Cycles with valid_in=0 SHALL insert bubbles that propagate as valid_out=0 exactly RW cycles later; gaps SHALL be preserved.
REQ-016 Stage data registers SHALL load only when the incoming stage-valid is 1; bubble cycles SHALL not disturb them.
REQ-017 root SHALL update only in cycles where valid_out becomes 1, and SHALL hold its last value while valid_out=0.
REQ-018 The value of a SHALL be ignored whenever valid_in=0.
REQ-019 Boundary: a=0 SHALL yield 0; a=2^WIDTH-1 SHALL yield 2^RW-1 (1023 at default); results SHALL be exact at k^2 and k^2-1.
REQ-020 No overflow or error output SHALL exist; every input has a representable root.

Reset
REQ-021 While reset=1 at a rising edge, all stage-valid bits, valid_out and root SHALL become 0.
REQ-022 Reset SHALL take priority over valid_in: an operand presented in a reset cycle SHALL be discarded.
REQ-023 Reset asserted mid-operation SHALL discard all in-flight operands; no valid_out SHALL appear for them afterwards.
REQ-024 The first operand accepted after reset is released SHALL follow normal RW-cycle latency.

Verification
REQ-025 The bench SHALL apply reset 1 cycle, then valid_in=1 with a=441, 1737, then a 2-cycle gap, then a=5833 -> expect root 21, 41, then two valid_out=0 cycles with root holding 41, then root 76, each RW cycles after issue.
REQ-026 The bench SHALL apply a=0, 1, 3, 4, 1046528, 1046529, 1048575 back-to-back -> expect root 0, 1, 1, 2, 1022, 1023, 1023 on consecutive cycles.
REQ-027 The bench SHALL hold valid_in=0 while toggling a randomly for 20 cycles -> expect valid_out to stay 0 and root unchanged.
REQ-028 The bench SHALL issue 5 operands, then assert reset for 1 cycle 3 cycles later -> expect valid_out=0 and root=0 next cycle, with no stale results afterwards; a fresh a=100 then SHALL yield 10 after RW cycles.
REQ-029 The bench SHALL drive 10000 random operands with random valid_in density -> expect every result to equal floor(sqrt(a)) and the count and order of valid_out pulses to match the issued operands.
